// File: rtl/regfile_arbiter.sv
// Round-robin arbiter/sequencer placing two requesters in front of
// an 8 x 16 register file; returns read data to the issuing master.
module regfile_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              M0_Req,
  input  logic              M0_WrEn,
  input  logic [ADDR_W-1:0] M0_Addr,
  input  logic [DATA_W-1:0] M0_WrData,
  output logic              M0_Gnt,
  output logic              M0_RdValid,
  output logic [DATA_W-1:0] M0_RdData,
  input  logic              M1_Req,
  input  logic              M1_WrEn,
  input  logic [ADDR_W-1:0] M1_Addr,
  input  logic [DATA_W-1:0] M1_WrData,
  output logic              M1_Gnt,
  output logic              M1_RdValid,
  output logic [DATA_W-1:0] M1_RdData,
  output logic [ADDR_W-1:0] RF_Address,
  output logic              RF_WrEn,
  output logic              RF_RdEn,
  output logic [DATA_W-1:0] RF_WrData,
  input  logic [DATA_W-1:0] RF_RdData
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    RD_DATA
  } state_t;

  state_t              state_q;
  logic                last_q;
  logic                owner_q;
  logic                gnt0_q;
  logic                gnt1_q;
  logic                rdv0_q;
  logic                rdv1_q;
  logic [DATA_W-1:0]   rd0_q;
  logic [DATA_W-1:0]   rd1_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                wren_q;
  logic                rden_q;

  logic                any_req;
  logic                win_d;
  logic                wr_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d;

  // On a tie the master that did not win last time goes first
  assign any_req = M0_Req | M1_Req;
  assign win_d   = (M0_Req & M1_Req) ? ~last_q : M1_Req;
  assign wr_d    = win_d ? M1_WrEn   : M0_WrEn;
  assign addr_d  = win_d ? M1_Addr   : M0_Addr;
  assign wdata_d = win_d ? M1_WrData : M0_WrData;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      rdv0_q  <= 1'b0;
      rdv1_q  <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wren_q  <= 1'b0;
      rden_q  <= 1'b0;
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      rdv0_q <= 1'b0;
      rdv1_q <= 1'b0;
      wren_q <= 1'b0;
      rden_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            last_q  <= win_d;
            owner_q <= win_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wren_q  <= wr_d;
            rden_q  <= ~wr_d;
            gnt0_q  <= ~win_d;
            gnt1_q  <= win_d;
            state_q <= wr_d ? WRITE : READ;
          end
        end
        WRITE: state_q <= IDLE;
        READ:  state_q <= RD_DATA;
        RD_DATA: begin
          if (owner_q) begin
            rd1_q  <= RF_RdData;
            rdv1_q <= 1'b1;
          end else begin
            rd0_q  <= RF_RdData;
            rdv0_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign M0_Gnt     = gnt0_q;
  assign M1_Gnt     = gnt1_q;
  assign M0_RdValid = rdv0_q;
  assign M1_RdValid = rdv1_q;
  assign M0_RdData  = rd0_q;
  assign M1_RdData  = rd1_q;
  assign RF_Address = addr_q;
  assign RF_WrData  = wdata_q;
  assign RF_WrEn    = wren_q;
  assign RF_RdEn    = rden_q;

endmodule
